// File: rtl/omsp_spm_ctrl_pkg.sv
// omsp_spm_ctrl_pkg: shared state, op and SM ID encodings for the SPM sequencer
package omsp_spm_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_UPDATE, ST_RESP} state_t;
  typedef enum logic {OP_PROTECT, OP_UNPROTECT} op_t;
  localparam int SM_ID_NONE  = 0;
  localparam int SM_ID_FIRST = 1;
endpackage

// File: rtl/omsp_spm_slot_sel.sv
// omsp_spm_slot_sel: lowest-set-bit priority encoder with found flag
module omsp_spm_slot_sel #(
  parameter int N     = 4,
  parameter int IDX_W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/omsp_spm_ctrl.sv
// omsp_spm_ctrl: protect/unprotect sequencer driving per-slot SPM strobes and allocating SM IDs
module omsp_spm_ctrl
  import omsp_spm_ctrl_pkg::*;
#(
  parameter int NUM_SPMS = 4,
  parameter int ID_W     = 16
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                protect_req,
  input  logic                unprotect_req,
  input  logic [15:0]         r12,
  input  logic [15:0]         r13,
  input  logic [15:0]         r14,
  input  logic [15:0]         r15,
  input  logic [NUM_SPMS-1:0] spm_enabled,
  input  logic [NUM_SPMS-1:0] spm_executing,
  input  logic [NUM_SPMS-1:0] spm_violation,
  output logic                check_new_spm,
  output logic [NUM_SPMS-1:0] update_spm,
  output logic                enable_spm,
  output logic                disable_spm,
  output logic [ID_W-1:0]     next_id,
  output logic                busy,
  output logic                done,
  output logic [ID_W-1:0]     ret_id
);
  localparam int IDX_W = NUM_SPMS > 1 ? $clog2(NUM_SPMS) : 1;
  localparam logic [ID_W-1:0] ID_NONE  = ID_W'(SM_ID_NONE);
  localparam logic [ID_W-1:0] ID_FIRST = ID_W'(SM_ID_FIRST);
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [15:0] r12_q, r12_d, r13_q, r13_d, r14_q, r14_d, r15_q, r15_d;
  logic [IDX_W-1:0] slot_q, slot_d, free_idx, exe_idx;
  logic found_q, found_d, free_found, exe_found, cfg_ok, fail;
  logic [ID_W-1:0] next_id_q, next_id_d, ret_id_q, ret_id_d;
  omsp_spm_slot_sel #(.N(NUM_SPMS), .IDX_W(IDX_W)) u_free_sel (
    .req(~spm_enabled), .idx(free_idx), .found(free_found)
  );
  omsp_spm_slot_sel #(.N(NUM_SPMS), .IDX_W(IDX_W)) u_exe_sel (
    .req(spm_executing & spm_enabled), .idx(exe_idx), .found(exe_found)
  );
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    r12_d     = r12_q;
    r13_d     = r13_q;
    r14_d     = r14_q;
    r15_d     = r15_q;
    slot_d    = slot_q;
    found_d   = found_q;
    next_id_d = next_id_q;
    ret_id_d  = ret_id_q;
    cfg_ok    = (r12_q < r13_q) && (r14_q <= r15_q);
    fail      = |spm_violation || !cfg_ok || !found_q;
    case (state_q)
      ST_IDLE: begin
        if (protect_req) begin
          op_d    = OP_PROTECT;
          r12_d   = r12;
          r13_d   = r13;
          r14_d   = r14;
          r15_d   = r15;
          slot_d  = free_idx;
          found_d = free_found;
          state_d = ST_CHECK;
        end else if (unprotect_req) begin
          op_d     = OP_UNPROTECT;
          slot_d   = exe_idx;
          found_d  = exe_found;
          state_d  = exe_found ? ST_UPDATE : ST_RESP;
          ret_id_d = exe_found ? ret_id_q : ID_NONE;
        end
      end
      ST_CHECK: begin
        state_d  = fail ? ST_RESP : ST_UPDATE;
        ret_id_d = fail ? ID_NONE : ret_id_q;
      end
      ST_UPDATE: begin
        state_d   = ST_RESP;
        ret_id_d  = (op_q == OP_PROTECT) ? next_id_q : ID_FIRST;
        next_id_d = (op_q != OP_PROTECT) ? next_id_q :
                    (next_id_q == '1) ? ID_FIRST : next_id_q + ID_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_PROTECT;
      r12_q     <= '0;
      r13_q     <= '0;
      r14_q     <= '0;
      r15_q     <= '0;
      slot_q    <= '0;
      found_q   <= 1'b0;
      next_id_q <= ID_FIRST;
      ret_id_q  <= ID_NONE;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      r12_q     <= r12_d;
      r13_q     <= r13_d;
      r14_q     <= r14_d;
      r15_q     <= r15_d;
      slot_q    <= slot_d;
      found_q   <= found_d;
      next_id_q <= next_id_d;
      ret_id_q  <= ret_id_d;
    end
  end
  assign busy          = state_q != ST_IDLE;
  assign done          = state_q == ST_RESP;
  assign check_new_spm = state_q == ST_CHECK;
  assign update_spm    = (state_q == ST_UPDATE) ? NUM_SPMS'(1) << slot_q : '0;
  assign enable_spm    = (state_q == ST_UPDATE) && (op_q == OP_PROTECT);
  assign disable_spm   = (state_q == ST_UPDATE) && (op_q == OP_UNPROTECT);
  assign next_id       = next_id_q;
  assign ret_id        = ret_id_q;
endmodule

// File: tb/tb_omsp_spm_ctrl.sv
// tb_omsp_spm_ctrl: scoreboard-based self-checking bench for omsp_spm_ctrl
module tb_omsp_spm_ctrl;
  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        protect_req = 1'b0;
  logic        unprotect_req = 1'b0;
  logic [15:0] r12 = '0, r13 = '0, r14 = '0, r15 = '0;
  logic [3:0]  spm_enabled = '0, spm_executing = '0, spm_violation = '0;
  logic        check_new_spm, enable_spm, disable_spm, busy, done;
  logic [3:0]  update_spm;
  logic [15:0] next_id, ret_id;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  omsp_spm_ctrl #(.NUM_SPMS(4), .ID_W(16)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .protect_req(protect_req), .unprotect_req(unprotect_req),
    .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .spm_enabled(spm_enabled), .spm_executing(spm_executing), .spm_violation(spm_violation),
    .check_new_spm(check_new_spm), .update_spm(update_spm),
    .enable_spm(enable_spm), .disable_spm(disable_spm),
    .next_id(next_id), .busy(busy), .done(done), .ret_id(ret_id)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask
  task automatic set_regs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    r12 = a;
    r13 = b;
    r14 = c;
    r15 = d;
  endtask
  task automatic run(input bit p, input bit u, input bit viol, input logic [15:0] exp_ret, input logic [3:0] exp_upd);
    protect_req = p;
    unprotect_req = u;
    exp_q.push_back(exp_ret);
    tick;
    protect_req = 1'b0;
    unprotect_req = 1'b0;
    chk("busy", busy, 1);
    chk("check_strobe", check_new_spm, p);
    if (p) begin
      chk("upd_in_check", update_spm, 0);
      spm_violation = viol ? 4'b0001 : 4'b0000;
      tick;
      spm_violation = '0;
    end
    if (exp_upd != 0) begin
      chk("upd", update_spm, exp_upd);
      chk("en", enable_spm, p);
      chk("dis", disable_spm, !p);
      tick;
    end
    chk("done", done, 1);
    chk("upd_in_resp", update_spm, 0);
    tick;
    chk("idle", busy, 0);
    chk("done_pulse", done, 0);
  endtask
  always @(negedge mclk) begin
    chk("excl", ($countones(update_spm) > 1) || (enable_spm && disable_spm) ||
                (check_new_spm && update_spm != 0), 0);
    if (done) begin
      if (exp_q.size() == 0) chk("unexp_done", done, 0);
      else chk("ret_id", ret_id, exp_q.pop_front());
    end
  end
  initial begin
    tick;
    tick;
    puc_rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_next_id", next_id, 16'h0001);
    chk("rst_ret_id", ret_id, 0);
    chk("rst_upd", {update_spm, check_new_spm, enable_spm, disable_spm}, 0);
    set_regs(16'h8000, 16'h8100, 16'h0200, 16'h0300);
    run(1, 0, 0, 16'h0001, 4'b0001);
    chk("next_id_2", next_id, 16'h0002);
    spm_enabled = 4'b0001;
    set_regs(16'h80F0, 16'h8200, 16'h0200, 16'h0300);
    run(1, 0, 1, 16'h0000, 4'b0000);
    chk("next_id_overlap", next_id, 16'h0002);
    set_regs(16'h9000, 16'h9000, 16'h0200, 16'h0300);
    run(1, 0, 0, 16'h0000, 4'b0000);
    set_regs(16'h9000, 16'h9100, 16'h0400, 16'h0300);
    run(1, 0, 0, 16'h0000, 4'b0000);
    chk("next_id_invalid", next_id, 16'h0002);
    set_regs(16'hA000, 16'hA100, 16'h0500, 16'h0500);
    run(1, 0, 0, 16'h0002, 4'b0010);
    chk("next_id_3", next_id, 16'h0003);
    spm_enabled = 4'b1111;
    run(1, 0, 0, 16'h0000, 4'b0000);
    chk("next_id_full", next_id, 16'h0003);
    spm_executing = 4'b0100;
    run(0, 1, 0, 16'h0001, 4'b0100);
    chk("next_id_unprot", next_id, 16'h0003);
    spm_executing = 4'b0000;
    run(0, 1, 0, 16'h0000, 4'b0000);
    spm_enabled = 4'b0110;
    spm_executing = 4'b0110;
    run(0, 1, 0, 16'h0001, 4'b0010);
    force dut.next_id_q = 16'hFFFF;
    tick;
    release dut.next_id_q;
    chk("next_id_forced", next_id, 16'hFFFF);
    spm_enabled = 4'b1110;
    spm_executing = 4'b0010;
    set_regs(16'hB000, 16'hB100, 16'h0600, 16'h0700);
    run(1, 1, 0, 16'hFFFF, 4'b0001);
    chk("next_id_wrap", next_id, 16'h0001);
    repeat (3) tick;
    chk("unprot_dropped", busy, 0);
    spm_enabled = 4'b0000;
    spm_executing = 4'b0000;
    run(1, 0, 0, 16'h0001, 4'b0001);
    chk("next_id_pre_rst", next_id, 16'h0002);
    protect_req = 1'b1;
    tick;
    protect_req = 1'b0;
    tick;
    chk("rst_mid_upd", update_spm, 4'b0001);
    puc_rst = 1'b1;
    tick;
    puc_rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_upd0", update_spm, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_next_id", next_id, 16'h0001);
    chk("rst_mid_en", enable_spm, 0);
    repeat (4) tick;
    chk("rst_mid_quiet", busy, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/omsp_spm_ctrl.md
Name: omsp_spm_ctrl

Overview:
- Sequencer that owns the N per-module SPM protection instances (one per SM slot).
- Receives protect and unprotect commands from the execution unit and runs the overlap check across all slots.
- Picks a free slot and issues the one-cycle update/enable/disable strobes to it.
- Allocates monotonically increasing SM IDs and returns a result (new ID, or 0 on failure) to the core.

Parameters:
- NUM_SPMS, 4, number of SPM slots controlled (1..16).
- ID_W, 16, width of SM identifiers and of the next_id counter.

Ports:
- mclk  in  1  system clock
- puc_rst  in  1  synchronous active-high reset
- protect_req  in  1  one-cycle request: create SM from r12..r15
- unprotect_req  in  1  one-cycle request: disable the SM currently executing
- r12, r13, r14, r15  in  16 each  public start/end, secret start/end of the requested SM
- spm_enabled  in  NUM_SPMS  per-slot enabled flags
- spm_executing  in  NUM_SPMS  per-slot "PC inside public section" flags
- spm_violation  in  NUM_SPMS  per-slot violation outputs
- check_new_spm  out  1  overlap-check strobe, broadcast to all slots
- update_spm  out  NUM_SPMS  one-hot update strobe, per slot
- enable_spm  out  1  qualifies update_spm as a create
- disable_spm  out  1  qualifies update_spm as a destroy
- next_id  out  ID_W  ID given to the slot on create
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- ret_id  out  ID_W  result, valid with done: new ID on protect, 1 on unprotect success, 0 on failure

Behaviour:
- Reset (checked first every cycle; clears everything on the next mclk edge):
  - state IDLE, next_id=1, ret_id=0.
  - done, busy, check_new_spm, enable_spm, disable_spm all 0; update_spm all 0.
  - Reset during any state aborts the operation. No update strobe is issued after the reset edge.
- States: IDLE, CHECK, UPDATE, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If protect_req and unprotect_req are both high, protect wins and unprotect is dropped.
  - Requests arriving while busy are ignored; the core stalls on busy.
- Protect path (request sampled at edge N):
  - On acceptance, latch r12..r15, op, and the lowest-index slot with spm_enabled=0 (free_slot, free_found).
  - N+1, CHECK: check_new_spm=1 for exactly one cycle.
    - cfg_ok = (r12<r13) & (r14<=r15), computed on the latched values.
    - fail if any spm_violation bit is set, or !cfg_ok, or !free_found.
    - fail goes to RESP with ret_id=0; otherwise go to UPDATE.
  - N+2, UPDATE: update_spm[free_slot]=1 and enable_spm=1 for one cycle. next_id is stable during this cycle and increments at its end.
  - N+3, RESP: done=1; ret_id holds the ID just assigned.
- next_id wrap: it increments by 1 per successful create. 0xFFFF wraps to 1, because 0 is reserved as "no SM".
- Unprotect path:
  - On acceptance, latch the lowest set index of spm_executing & spm_enabled.
  - If none is set: RESP at N+1 with ret_id=0.
  - Otherwise: UPDATE at N+1 with update_spm[slot]=1 and disable_spm=1, then RESP at N+2 with ret_id=1.
  - next_id is unchanged on unprotect.
- RESP: done=1 for one cycle, then return to IDLE. ret_id holds its value until the next done.
- Strobe exclusivity: update_spm is 0 outside UPDATE, and at most one bit is set. enable_spm and disable_spm are never high together. check_new_spm is high only in CHECK.
- Outputs are registered. ret_id is updated on entry to RESP.

Decomposition:
- Package omsp_spm_ctrl_pkg:
  - state encodings (2-bit).
  - constants SM_ID_NONE=0 and SM_ID_FIRST=1.
  - op encoding (OP_PROTECT, OP_UNPROTECT).
- Sub-module omsp_spm_slot_sel: parameterised lowest-set-bit priority encoder with a found flag. It is used twice: free-slot search on ~spm_enabled, and executing-slot search on spm_executing&spm_enabled.

Test Plan:
- Protect into an empty system, r12..r15 = 0x8000/0x8100/0x0200/0x0300:
  - check_new_spm at N+1, update_spm=0001 with enable_spm at N+2.
  - done with ret_id=1 at N+3; next_id becomes 2.
- Overlap: slot0 enabled; protect with 0x80F0/0x8200, tb drives spm_violation[0]=1 during CHECK → RESP at N+2, ret_id=0, no update strobe, next_id unchanged.
- Invalid config r12=0x9000, r13=0x9000 → ret_id=0 at N+2; no update strobe.
- All 4 slots enabled, then protect → ret_id=0. After that, unprotect with spm_executing=0100 → update_spm=0100 with disable_spm at N+1, ret_id=1 at N+2.
- Wrap and priority: force next_id=0xFFFF and create → ret_id=0xFFFF, next_id=1. Assert protect_req and unprotect_req together → protect handled, unprotect dropped.
- Reset mid-op: assert puc_rst during UPDATE → next cycle state IDLE, update_spm=0, done=0, next_id=1.
